// File: rtl/keypad_pkg.sv
// Shared types and default constants for the key display sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keypad_pkg;

  // Hex code reported by the keypad scanner.
  typedef logic [3:0] key_code_t;

  // Key acceptance FSM states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    ACCEPT     = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } kd_state_t;

  // Default debounce window in clk cycles (press and release).
  localparam int DEBOUNCE_CYCLES_DEF = 20000;
  // Default number of clk cycles each display digit stays selected.
  localparam int REFRESH_CYCLES_DEF  = 1000;

endpackage

// File: rtl/key_display_sequencer_if.sv
// Scanner and display signal bundle for the key display sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; scan_hold is the only feedback that throttles the scanner.
interface key_display_sequencer_if;
  import keypad_pkg::*;

  logic      key_valid;
  key_code_t key_code;
  logic      scan_hold;
  key_code_t prev_num;
  logic      key_strobe;
  key_code_t digit_new;
  key_code_t digit_old;
  logic      disp_sel;
  key_code_t disp_code;

  // Scanner / environment side.
  modport master (
    output key_valid, key_code,
    input  scan_hold, prev_num, key_strobe, digit_new, digit_old, disp_sel, disp_code
  );

  // Sequencer side.
  modport slave (
    input  key_valid, key_code,
    output scan_hold, prev_num, key_strobe, digit_new, digit_old, disp_sel, disp_code
  );

endinterface

// File: rtl/refresh_divider.sv
// Free-running display refresh divider: toggles the digit select every REFRESH_CYCLES clocks.
// Latency: o_disp_sel changes on the clock edge where the counter wraps to 0.
// Backpressure: none; runs unconditionally and is never reset by key activity.
module refresh_divider
  import keypad_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic clk,
  input  logic nrst,
  output logic o_disp_sel
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_disp_sel;

  // Count 0..REFRESH_CYCLES-1 and flip the selected digit on each wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt      <= '0;
      r_disp_sel <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt      <= '0;
      r_disp_sel <= ~r_disp_sel;
    end else begin
      r_cnt      <= r_cnt + 1'b1;
    end
  end

  assign o_disp_sel = r_disp_sel;

endmodule

// File: rtl/key_display_sequencer.sv
// Debounces keypad presses/releases, keeps the last two accepted keys and multiplexes them to a 2-digit display.
// Latency: accept strobe DEBOUNCE_CYCLES+1 cycles after a stable press; disp_code lags disp_sel/digits by 1 cycle.
// Backpressure: scan_hold freezes the scanner from press detection until the release is debounced.
// Build option: define KEY_DEBOUNCE_EN for counted debounce; otherwise press/release filters last one cycle.
module key_display_sequencer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REFRESH_CYCLES  = REFRESH_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    nrst,
  key_display_sequencer_if.slave  kd
);

  kd_state_t r_state;
  key_code_t r_cand;
  key_code_t r_digit_new;
  key_code_t r_digit_old;
  key_code_t r_disp_code;
  logic      r_key_strobe;
  logic      r_scan_hold;
  logic      w_disp_sel;

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
`else
  // Debounce length has no effect when the filter is compiled out.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
  end
`endif

  // Key acceptance FSM; strobe, digits and scan_hold are registered alongside the state change.
  // Digits are loaded on entry to ACCEPT so they become visible together with key_strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_cand       <= '0;
      r_digit_new  <= '0;
      r_digit_old  <= '0;
      r_key_strobe <= 1'b0;
      r_scan_hold  <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_key_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (kd.key_valid) begin
            r_cand      <= kd.key_code;
            r_state     <= PRESS_DB;
            r_scan_hold <= 1'b1;
`ifdef KEY_DEBOUNCE_EN
            r_cnt       <= '0;
`endif
          end
        end

        PRESS_DB: begin
          if (!kd.key_valid || (kd.key_code != r_cand)) begin
            r_state     <= IDLE;
            r_scan_hold <= 1'b0;
          end else begin
`ifdef KEY_DEBOUNCE_EN
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state      <= ACCEPT;
              r_key_strobe <= 1'b1;
              r_digit_old  <= r_digit_new;
              r_digit_new  <= r_cand;
            end
`else
            r_state      <= ACCEPT;
            r_key_strobe <= 1'b1;
            r_digit_old  <= r_digit_new;
            r_digit_new  <= r_cand;
`endif
          end
        end

        ACCEPT: begin
          r_state <= HELD;
        end

        HELD: begin
          // A code change while still pressed is ignored; only a release matters here.
          if (!kd.key_valid) begin
            r_state <= RELEASE_DB;
`ifdef KEY_DEBOUNCE_EN
            r_cnt   <= '0;
`endif
          end
        end

        RELEASE_DB: begin
          if (kd.key_valid) begin
            r_state <= HELD;
          end else begin
`ifdef KEY_DEBOUNCE_EN
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state     <= IDLE;
              r_scan_hold <= 1'b0;
            end
`else
            r_state     <= IDLE;
            r_scan_hold <= 1'b0;
`endif
          end
        end

        default: begin
          r_state     <= IDLE;
          r_scan_hold <= 1'b0;
        end
      endcase
    end
  end

  refresh_divider #(
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_refresh_divider (
    .clk        (clk),
    .nrst       (nrst),
    .o_disp_sel (w_disp_sel)
  );

  // Register the selected digit so the display bus is glitch-free.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_disp_code <= '0;
    end else begin
      r_disp_code <= w_disp_sel ? r_digit_old : r_digit_new;
    end
  end

  assign kd.scan_hold  = r_scan_hold;
  assign kd.prev_num   = r_digit_new;
  assign kd.key_strobe = r_key_strobe;
  assign kd.digit_new  = r_digit_new;
  assign kd.digit_old  = r_digit_old;
  assign kd.disp_sel   = w_disp_sel;
  assign kd.disp_code  = r_disp_code;

endmodule

// File: tb/tb_key_display_sequencer.sv
// Directed bench for key_display_sequencer with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising clk edge.
// Press/release timing follows KEY_DEBOUNCE_EN so the bench matches either build.
module tb_key_display_sequencer;
  import keypad_pkg::*;

  localparam int DB = 4;
  localparam int RF = 8;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT    = DB;
  localparam int BOUNCE = 2;
`else
  localparam int LAT    = 1;
  localparam int BOUNCE = 1;
`endif

  logic clk;
  logic nrst;
  int   tests;
  int   fails;
  int   strobe_cnt;
  int   toggles;
  int   t1;
  int   t2;
  logic prev_sel;
  int   strobe_at;
  int   strobe_seen;

  // Reference refresh model
  int   ref_cnt;
  logic ref_sel;
  logic ref_sel_d;

  key_display_sequencer_if bus ();

  key_display_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .REFRESH_CYCLES  (RF)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .kd   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ref_cnt   <= 0;
      ref_sel   <= 1'b0;
      ref_sel_d <= 1'b0;
    end else begin
      ref_cnt   <= (ref_cnt == RF - 1) ? 0 : ref_cnt + 1;
      if (ref_cnt == RF - 1) ref_sel <= ~ref_sel;
      ref_sel_d <= ref_sel;
    end
  end

  initial strobe_cnt = 0;
  always @(posedge clk) begin
    if (bus.key_strobe === 1'b1) strobe_cnt++;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_scan_hold"},  32'(bus.scan_hold),  32'd0);
    chk({pfx, "_key_strobe"}, 32'(bus.key_strobe), 32'd0);
    chk({pfx, "_digit_new"},  32'(bus.digit_new),  32'd0);
    chk({pfx, "_digit_old"},  32'(bus.digit_old),  32'd0);
    chk({pfx, "_prev_num"},   32'(bus.prev_num),   32'd0);
    chk({pfx, "_disp_sel"},   32'(bus.disp_sel),   32'd0);
    chk({pfx, "_disp_code"},  32'(bus.disp_code),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    nrst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    #2;
    nrst = 1'b0;
    #1;
    chk_all_zero("reset");
    step(2);
    nrst = 1'b1;

    // Refresh: select stays on the new digit for 8 edges, then flips.
    step(RF - 1);
    chk("refresh_hold", 32'(bus.disp_sel), 32'd0);
    step(1);
    chk("refresh_wrap", 32'(bus.disp_sel), 32'd1);

    // Stable press of 6 held for 10 cycles.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h6;
    step(1);
    chk("press6_scan_hold", 32'(bus.scan_hold), 32'd1);
    chk("press6_no_early_strobe", 32'(bus.key_strobe), 32'd0);
    strobe_seen = 0;
    strobe_at   = 0;
    for (int k = 2; k <= 10; k++) begin
      step(1);
      if (bus.key_strobe === 1'b1) begin
        strobe_seen++;
        strobe_at = k;
      end
    end
    chk("press6_strobe_count", 32'(strobe_seen), 32'd1);
    chk("press6_strobe_cycle", 32'(strobe_at), 32'(LAT + 1));
    chk("press6_digit_new", 32'(bus.digit_new), 32'h6);
    chk("press6_digit_old", 32'(bus.digit_old), 32'h0);
    chk("press6_prev_num",  32'(bus.prev_num),  32'h6);
    chk("press6_scan_hold_held", 32'(bus.scan_hold), 32'd1);

    // Release with a one-cycle glitch while in RELEASE_DB.
    bus.key_valid = 1'b0;
    step(1);
    bus.key_valid = 1'b1;
    step(1);
    chk("glitch_scan_hold", 32'(bus.scan_hold), 32'd1);
    bus.key_valid = 1'b0;
    step(LAT);
    chk("release_still_held", 32'(bus.scan_hold), 32'd1);
    step(1);
    chk("release_idle", 32'(bus.scan_hold), 32'd0);
    chk("glitch_no_second_strobe", 32'(strobe_cnt), 32'd1);

    // Bounce: 3 appears briefly and drops.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h3;
    step(BOUNCE);
    chk("bounce_scan_hold", 32'(bus.scan_hold), 32'd1);
    bus.key_valid = 1'b0;
    step(1);
    chk("bounce_idle", 32'(bus.scan_hold), 32'd0);
    step(3);
    chk("bounce_no_strobe", 32'(strobe_cnt), 32'd1);
    chk("bounce_digit_new", 32'(bus.digit_new), 32'h6);

    // Second key 3, then a mid-hold change to 8.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h3;
    step(1 + LAT);
    chk("press3_strobe", 32'(bus.key_strobe), 32'd1);
    chk("press3_digit_new", 32'(bus.digit_new), 32'h3);
    chk("press3_digit_old", 32'(bus.digit_old), 32'h6);
    chk("press3_prev_num",  32'(bus.prev_num),  32'h3);
    step(1);
    chk("press3_strobe_one_cycle", 32'(bus.key_strobe), 32'd0);
    bus.key_code = 4'h8;
    step(6);
    chk("hold8_digit_new", 32'(bus.digit_new), 32'h3);
    chk("hold8_digit_old", 32'(bus.digit_old), 32'h6);
    chk("hold8_no_strobe", 32'(strobe_cnt), 32'd2);
    bus.key_valid = 1'b0;
    step(LAT + 1);
    chk("release3_idle", 32'(bus.scan_hold), 32'd0);

    // Display multiplexing of 3 (new) and 6 (old).
    prev_sel = bus.disp_sel;
    toggles  = 0;
    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("disp_sel", 32'(bus.disp_sel), 32'(ref_sel));
      chk("disp_code", 32'(bus.disp_code), ref_sel_d ? 32'h6 : 32'h3);
      if (bus.disp_sel !== prev_sel) begin
        toggles++;
        if (toggles == 1) t1 = k;
        else t2 = k;
      end
      prev_sel = bus.disp_sel;
    end
    chk("disp_toggle_count", 32'(toggles), 32'd2);
    chk("disp_toggle_period", 32'(t2 - t1), 32'(RF));

    // Reset in the middle of a press of A.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hA;
    step(1);
    chk("pressA_scan_hold", 32'(bus.scan_hold), 32'd1);
    nrst = 1'b0;
    #1;
    chk_all_zero("midreset");
    step(2);
    nrst = 1'b1;
    step(LAT);
    chk("after_reset_pressing", 32'(bus.scan_hold), 32'd1);
    bus.key_valid = 1'b0;
    step(1);
    chk("after_reset_idle", 32'(bus.scan_hold), 32'd0);
    step(4);
    chk("after_reset_no_accept", 32'(strobe_cnt), 32'd2);
    chk("after_reset_digit_new", 32'(bus.digit_new), 32'h0);

    // A full press after reset is accepted with cleared history.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hA;
    step(LAT);
    chk("pressA_not_yet", 32'(bus.key_strobe), 32'd0);
    step(1);
    chk("pressA_strobe", 32'(bus.key_strobe), 32'd1);
    chk("pressA_digit_new", 32'(bus.digit_new), 32'hA);
    chk("pressA_digit_old", 32'(bus.digit_old), 32'h0);
    bus.key_valid = 1'b0;
    step(LAT + 2);
    chk("pressA_released", 32'(bus.scan_hold), 32'd0);
    chk("pressA_strobe_total", 32'(strobe_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_display_sequencer.md
KEY_DISPLAY_SEQUENCER -- requirements
Module: key_display_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, SHALL set the number of stable clk cycles required on a key press and on a key release.
REQ-002 Parameter REFRESH_CYCLES, default 1000, SHALL set the number of clk cycles each display digit stays selected.
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 key_valid  input  1  scanner reports a key is pressed.
REQ-006 key_code  input  4  scanner hex code of the pressed key; meaningful only when key_valid=1.
REQ-007 scan_hold  output  1  tells the scanner to freeze column drive.
REQ-008 prev_num  output  4  last accepted key, fed back to the scanner.
REQ-009 key_strobe  output  1  one-cycle pulse on each accepted key.
REQ-010 digit_new  output  4  most recent accepted key.
REQ-011 digit_old  output  4  key accepted before digit_new.
REQ-012 disp_sel  output  1  0 selects the right (new) digit, 1 selects the left (old) digit.
REQ-013 disp_code  output  4  code of the currently selected digit.

Function
REQ-014 FSM states SHALL be IDLE, PRESS_DB, ACCEPT, HELD, RELEASE_DB.
REQ-015 IDLE: key_valid=1 SHALL latch cand<=key_code, clear cnt, and go to PRESS_DB; otherwise stay in IDLE.
REQ-016 PRESS_DB: key_valid=0 or key_code!=cand SHALL return to IDLE; otherwise cnt SHALL increment, and cnt==DEBOUNCE_CYCLES-1 SHALL go to ACCEPT.
REQ-017 ACCEPT (exactly one cycle): digit_old<=digit_new, digit_new<=cand, key_strobe=1; next state SHALL be HELD.
REQ-018 HELD: key_valid=0 SHALL clear cnt and go to RELEASE_DB; a changed key_code while key_valid=1 SHALL be ignored.
REQ-019 RELEASE_DB: key_valid=1 SHALL return to HELD with no new accept; otherwise cnt SHALL increment, and cnt==DEBOUNCE_CYCLES-1 SHALL go to IDLE.
REQ-020 scan_hold SHALL be 1 in PRESS_DB, ACCEPT, HELD and RELEASE_DB, and 0 in IDLE.
REQ-021 prev_num SHALL equal digit_new at all times.
REQ-022 Refresh counter SHALL count 0..REFRESH_CYCLES-1 and wrap to 0; disp_sel SHALL toggle on the cycle of the wrap.
REQ-023 disp_code SHALL be registered: disp_code<=disp_sel?digit_old:digit_new, i.e. one cycle of latency after a disp_sel or digit change.
REQ-024 The refresh counter SHALL run independently of the FSM; a key accept SHALL NOT reset it.
REQ-025 Repeated presses of the same key SHALL each be accepted after a full release, so digit_old==digit_new is a legal result.

Reset
REQ-026 nrst=0 SHALL immediately force: state=IDLE, cnt=0, cand=0, refresh counter=0, digit_new=0, digit_old=0, disp_sel=0, disp_code=0, key_strobe=0, scan_hold=0.
REQ-027 Reset asserted mid-debounce or in HELD SHALL discard cand; after release of reset, the first press SHALL require a full PRESS_DB.

Configuration
REQ-028 Macro KEY_DEBOUNCE_EN defined: PRESS_DB and RELEASE_DB SHALL behave as above.
REQ-029 Macro KEY_DEBOUNCE_EN undefined: PRESS_DB and RELEASE_DB SHALL each last exactly one cycle, with only the abort check applied, and the debounce counter SHALL not be instantiated.

Structure
REQ-030 Package keypad_pkg SHALL hold the FSM state enum, the 4-bit key_code_t typedef, and default constants for DEBOUNCE_CYCLES and REFRESH_CYCLES.
REQ-031 Sub-module refresh_divider SHALL implement the refresh counter and disp_sel toggle; the FSM and digit registers SHALL stay in the top module.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8, KEY_DEBOUNCE_EN defined)
REQ-032 Stable press: key_valid=1 with key_code=6 held for 10 cycles -> key_strobe pulses exactly once, 5 cycles after the press; digit_new=6, digit_old=0, prev_num=6; scan_hold=1 from the cycle after the press.
REQ-033 Bounce: key_code=3 held for 2 cycles, then key_valid=0 -> no strobe; FSM returns to IDLE and scan_hold returns to 0.
REQ-034 Second key: accept 6, full release, then press 3 -> digit_new=3, digit_old=6; a mid-hold change to key_code=8 is not accepted.
REQ-035 Release glitch: in RELEASE_DB, key_valid=1 for 1 cycle -> FSM goes back to HELD and no second strobe occurs.
REQ-036 Display: with digit_new=3 and digit_old=6, disp_sel toggles every 8 cycles and disp_code alternates 3/6, lagging disp_sel by 1 cycle.
REQ-037 Reset mid-PRESS_DB with key_code=A -> all outputs are 0 immediately, and no accept of A occurs after reset is released.
